uart_tx64: RTL and testbench
============================

UART_TX64 -- requirements
Module: uart_tx64

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, UART baud rate in bits/s.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  64  word to transmit; sampled only on acceptance.
REQ-006 data_valid  input  1  word-valid request from upstream.
REQ-007 data_ready  output  1  high when block can accept a word.
REQ-008 uart_txd  output  1  serial line, idle high.
REQ-009 busy  output  1  high from acceptance until final stop bit ends.
REQ-010 done  output  1  one-cycle pulse at end of the 8th byte's stop bit.

Function
REQ-011 CLKS_PER_BIT SHALL equal CLK_HZ/BIT_RATE (integer division); every line bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-012 Acceptance SHALL occur on a rising edge where data_valid && data_ready; data_in SHALL be latched into a 64-bit shift register that edge.
REQ-013 data_ready SHALL be high only in IDLE and SHALL fall the cycle after acceptance; data_valid while not ready SHALL be ignored, not queued.
REQ-014 Bytes SHALL be sent most-significant first: data_in[63:56], then [55:48], ... [7:0], matching the receive-side MSB-first assembly order.
REQ-015 Each byte frame: start bit (0), 8 data bits LSB first, optional parity (REQ-027), one stop bit (1).
REQ-016 uart_txd SHALL go low (start bit of byte 0) on the cycle after acceptance.
REQ-017 Next byte's start bit SHALL begin the cycle immediately after the previous stop bit's last cycle; no extra idle gap.
REQ-018 Word FSM states: IDLE -> SEND (byte active) -> NEXT (shift register left 8, byte count +1) -> SEND ... ; after byte 7 stop bit -> IDLE.
REQ-019 Byte counter SHALL be 3 bits, counting 0..7; reaching 7 with stop complete SHALL end the word, no wrap into a 9th byte.
REQ-020 done SHALL pulse high one cycle coinciding with return to IDLE; busy SHALL fall that same cycle; data_ready SHALL rise that same cycle.
REQ-021 A new word presented with data_valid during the done cycle SHALL be accepted that cycle (back-to-back words, no idle bit between words).
REQ-022 Changes to data_in after acceptance SHALL not affect the word in flight.

Reset
REQ-023 On rst: FSM to IDLE, uart_txd=1, data_ready=1, busy=0, done=0, byte counter=0, bit-timer=0, shift register=0.
REQ-024 rst asserted mid-frame SHALL abort the word immediately; line returns high next cycle; no done pulse; partial word discarded.
REQ-025 rst SHALL take priority over simultaneous data_valid.

Configuration
REQ-026 Macro UART_TX64_PARITY_EN selects parity.
REQ-027 Defined: an even-parity bit (XOR of the 8 data bits) SHALL follow bit 7, frame = 11 bits. Undefined: no parity bit, frame = 10 bits.

Structure
REQ-028 Shared package uart_pkg SHALL hold the CLKS_PER_BIT calculation function, the word-FSM state enum, and frame-length constants.
REQ-029 Sub-module uart_tx_byte SHALL serialize one byte (inputs byte, start; outputs txd, byte_done); uart_tx64 instantiates it once and sequences bytes.

Verification (CLK_HZ=1000, BIT_RATE=100 -> 10 clocks/bit)
REQ-030 Accept 64'h0123_4567_89AB_CDEF -> line decodes bytes 01,23,45,67,89,AB,CD,EF in order; done at cycle 800 after acceptance (880 with parity).
REQ-031 Byte 8'h01 with UART_TX64_PARITY_EN -> parity bit 1; byte 8'h03 -> parity bit 0; frames 110 cycles.
REQ-032 data_valid held high with two words -> second accepted on done cycle; line never idles between the two words; 16 bytes decoded correctly.
REQ-033 rst pulsed at cycle 350 of a word -> uart_txd=1 next cycle, data_ready=1, no done; next accepted word transmits cleanly.
REQ-034 data_valid pulsed while busy, data_in changed mid-word -> pulse ignored, transmitted bytes unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 64-bit UART transmitter: bit timing, word FSM states, frame sizes.
// UART_TX64_PARITY_EN adds an even-parity bit to every byte frame.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StNext
    } word_state_e;

    localparam int unsigned BYTES_PER_WORD = 8;

`ifdef UART_TX64_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as start, 8 data bits LSB first, optional parity, stop.
// UART_TX64_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       start,
    output logic       txd,
    output logic       byte_done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);
    // byte_done marks the cycle before the stop bit's final cycle, so the sequencer
    // can hand over the next byte exactly as the stop bit ends.
    localparam logic [3:0] PEN_IDX = (CLKS_PER_BIT == 1) ? 4'(FRAME_BITS - 2) : STOP_IDX;
    localparam logic [TW-1:0] PEN_T = (CLKS_PER_BIT == 1) ? '0 : TW'(CLKS_PER_BIT - 2);

    logic          active_q;
    logic [3:0]    idx_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    data_q;
    logic          txd_q;
    logic [3:0]    nxt_idx;
    logic          nxt_bit;

`ifdef UART_TX64_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (start) begin
            parity_q <= ^tx_byte;
        end
    end
`endif

    always_comb begin
        nxt_idx = idx_q + 4'd1;
        nxt_bit = 1'b1;
        if (nxt_idx <= 4'd8) begin
            nxt_bit = data_q[0];
        end
`ifdef UART_TX64_PARITY_EN
        else if (nxt_idx == 4'd9) begin
            nxt_bit = parity_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            timer_q  <= '0;
            data_q   <= '0;
            txd_q    <= 1'b1;
        end else if (start) begin
            active_q <= 1'b1;
            idx_q    <= '0;
            timer_q  <= '0;
            data_q   <= tx_byte;
            txd_q    <= 1'b0;
        end else if (active_q) begin
            if (timer_q == T_LAST) begin
                timer_q <= '0;
                if (idx_q == STOP_IDX) begin
                    active_q <= 1'b0;
                end else begin
                    idx_q <= nxt_idx;
                    txd_q <= nxt_bit;
                    if (nxt_idx <= 4'd8) begin
                        data_q <= data_q >> 1;
                    end
                end
            end else begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign txd       = txd_q;
    assign byte_done = active_q && (idx_q == PEN_IDX) && (timer_q == PEN_T);

endmodule

// File: rtl/uart_tx64.sv
// Transmits a 64-bit word as eight back-to-back UART byte frames, most-significant byte first.
// UART_TX64_PARITY_EN selects 11-bit frames with even parity (10-bit frames otherwise).
module uart_tx64
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BIT_RATE = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE);

    word_state_e state_q;
    logic [63:0] shift_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    logic        accept;
    logic        byte_start;
    logic [7:0]  byte_in;
    logic        byte_done;

    assign accept     = data_valid && ready_q;
    assign byte_start = accept || (state_q == StNext);
    // On acceptance the first byte comes straight from data_in; later bytes from the shifter.
    assign byte_in    = (state_q == StNext) ? shift_q[63:56] : data_in[63:56];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shift_q <= data_in;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (byte_done) begin
                        if (cnt_q == 3'(BYTES_PER_WORD - 1)) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            shift_q <= {shift_q[55:0], 8'h00};
                            cnt_q   <= cnt_q + 3'd1;
                            state_q <= StNext;
                        end
                    end
                end
                StNext: begin
                    state_q <= StSend;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .rst      (rst),
        .tx_byte  (byte_in),
        .start    (byte_start),
        .txd      (uart_txd),
        .byte_done(byte_done)
    );

    assign data_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_uart_tx64.sv
// Scoreboard bench for uart_tx64: a line decoder and a done watcher check against queued expectations.
// Frame arithmetic follows UART_TX64_PARITY_EN when defined.
module tb_uart_tx64;

    localparam int CLK_HZ   = 1000;
    localparam int BIT_RATE = 100;
    localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX64_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WORD = 8 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        uart_txd;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  exp_bytes[$];
    int          exp_acc[$];
    bit          abort_req = 1'b0;
    int          acc_pop;

    uart_tx64 #(
        .CLK_HZ  (CLK_HZ),
        .BIT_RATE(BIT_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .uart_txd  (uart_txd),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen or missing at cycle %0d", name, cyc);
    endtask

    // Line level at cycle rel of a word; cycle 1 is the one right after the accepting edge.
    function automatic logic model_bit(input logic [63:0] w, input int rel);
        int k = (rel - 1) / (FRAME * CPB);
        int b = ((rel - 1) % (FRAME * CPB)) / CPB;
        logic [7:0] by = w[63 - 8 * k -: 8];
        if (b == 0) return 1'b0;
        if (b <= 8) return by[b - 1];
        if (FRAME == 11 && b == 9) return ^by;
        return 1'b1;
    endfunction

    task automatic push_word(input logic [63:0] w);
        for (int k = 0; k < 8; k++) exp_bytes.push_back(w[63 - 8 * k -: 8]);
        exp_acc.push_back(cyc);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge right after acceptance.
    task automatic issue(input logic [63:0] w);
        chk("ready_before_accept", data_ready, 1);
        data_in    = w;
        data_valid = 1'b1;
        @(negedge clk);
        push_word(w);
        chk("txd_start_after_accept", uart_txd, 0);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", data_ready, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 2 * WORD) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) flag("done_timeout");
    endtask

    // Line decoder: samples each bit at its centre and pops the expected byte.
    initial begin : decoder
        logic [15:0] fr;
        logic [7:0]  eb;
        bit          ab;
        forever begin
            @(negedge clk);
            if (!rst && uart_txd === 1'b0) begin
                abort_req = 1'b0;
                ab = 1'b0;
                fr = '0;
                for (int b = 0; b < FRAME && !ab; b++) begin
                    for (int c = 0; c < ((b == 0) ? CPB / 2 : CPB); c++) begin
                        @(negedge clk);
                        if (abort_req) ab = 1'b1;
                    end
                    fr[b] = uart_txd;
                end
                if (!ab) begin
                    chk("start_bit", fr[0], 0);
                    chk("stop_bit", fr[FRAME - 1], 1);
                    if (exp_bytes.size() == 0) begin
                        flag("unexpected_byte");
                    end else begin
                        eb = exp_bytes.pop_front();
                        chk("byte_data", fr[8:1], eb);
`ifdef UART_TX64_PARITY_EN
                        chk("parity_bit", fr[9], ^eb);
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_acc.size() == 0) begin
                flag("unexpected_done");
            end else begin
                acc_pop = exp_acc.pop_front();
                chk("done_cycle", 64'(cyc - acc_pop + 1), WORD);
                chk("busy_at_done", busy, 0);
                chk("ready_at_done", data_ready, 1);
            end
        end
    end

    initial begin : watchdog
        #(40000 * 10);
        flag("global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        logic [63:0] w;
        logic [63:0] w2;

        repeat (3) @(negedge clk);
        chk("reset_txd", uart_txd, 1);
        chk("reset_ready", data_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed words, including bytes 01 (odd parity) and 03 (even parity)
        issue(64'h0123_4567_89AB_CDEF);
        data_valid = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        issue(64'h0103_0301_FF00_8055);
        data_valid = 1'b0;
        wait_done();
        repeat (7) @(negedge clk);

        // Valid pulse while busy and data_in changes mid-word must not disturb the word
        w = {$urandom, $urandom};
        issue(w);
        data_valid = 1'b0;
        repeat (199) @(negedge clk);
        data_in    = {$urandom, $urandom};
        data_valid = 1'b1;
        @(negedge clk);
        chk("ready_while_busy", data_ready, 0);
        data_valid = 1'b0;
        data_in    = {$urandom, $urandom};
        wait_done();
        repeat (3) @(negedge clk);

        // Back-to-back: valid held, second word taken on the done cycle
        w  = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        issue(w);
        data_in = w2;
        wait_done();
        @(negedge clk);
        push_word(w2);
        chk("b2b_txd_start", uart_txd, 0);
        chk("b2b_busy", busy, 1);
        data_valid = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // Reset at cycle 350 of a word (byte 3, data bit 3 is low); valid held with rst
        w = {$urandom, 8'h00, $urandom};
        w[39:32] = 8'h00;
        issue(w);
        data_valid = 1'b0;
        repeat (349) @(negedge clk);
        chk("line_before_reset", uart_txd, model_bit(w, 350));
        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = {$urandom, $urandom};
        abort_req  = 1'b1;
        exp_bytes.delete();
        exp_acc.delete();
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        chk("abort_txd_high", uart_txd, 1);
        chk("abort_ready", data_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2 * FRAME * CPB) @(negedge clk);
        w = {$urandom, $urandom};
        issue(w);
        data_valid = 1'b0;
        wait_done();

        // Random words with random idle gaps
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            w = {$urandom, $urandom};
            issue(w);
            data_valid = 1'b0;
            wait_done();
        end

        repeat (3 * CPB) @(negedge clk);
        chk("leftover_bytes", 64'(exp_bytes.size()), 0);
        chk("leftover_done", 64'(exp_acc.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
